lfsr_run_ctrl: RTL and testbench

// Register file and run sequencer for the n-bit LFSR application unit. Decodes AFU MMIO writes into

---
 rtl/lfsr_run_ctrl_if.sv | 22 ++
 rtl/lfsr_run_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_lfsr_run_ctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_run_ctrl_if.sv
// MMIO side of the LFSR run controller: write strobe/address/data plus
// the read request and its registered readback.
interface lfsr_run_ctrl_if #(
  parameter int unsigned n = 32
);
  logic          W;
  logic [15:0]   A;
  logic [n-1:0]  D;
  logic          rd_req;
  logic [15:0]   rd_addr;
  logic [63:0]   rd_data;

  modport master (
    output W, A, D, rd_req, rd_addr,
    input  rd_data
  );

  modport slave (
    input  W, A, D, rd_req, rd_addr,
    output rd_data
  );
endinterface

// File: rtl/lfsr_run_ctrl.sv
// Register file and run sequencer for the n-bit LFSR unit. Decodes MMIO
// writes into Poly/Seed/Ctrl/Count, drives LFSR load/enable for single-step,
// counted-burst and free-run modes, and serves registered readback.
module lfsr_run_ctrl #(
  parameter int unsigned n     = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic          clock,
  input  logic          reset,
  lfsr_run_ctrl_if.slave bus,
  output logic [n-1:0]  Poly,
  output logic          lfsr_load,
  output logic [n-1:0]  lfsr_seed,
  output logic          lfsr_en,
  input  logic [n-1:0]  Q,
  output logic          busy,
  output logic          done_irq
);

  localparam logic [15:0] A_POLY  = 16'h0010;
  localparam logic [15:0] A_SEED  = 16'h0012;
  localparam logic [15:0] A_CTRL  = 16'h0014;
  localparam logic [15:0] A_COUNT = 16'h0016;
  localparam logic [15:0] A_STAT  = 16'h0018;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP,
    S_BURST,
    S_FREE,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [n-1:0]       poly_q, poly_d;
  logic [n-1:0]       seed_q, seed_d;
  logic [1:0]         ctrl_q, ctrl_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               zero_q, zero_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               load_q, load_d;
  logic               irq_q;
  logic [63:0]        rd_q, rd_d;
  logic               running;
  logic               enter_done;
  logic               enter_idle;
  logic               wr_poly, wr_seed, wr_ctrl, wr_count, wr_stat;
  logic               abort;

  assign running  = (state_q == S_STEP) || (state_q == S_BURST) || (state_q == S_FREE);
  assign wr_poly  = bus.W && (bus.A == A_POLY);
  assign wr_seed  = bus.W && (bus.A == A_SEED);
  assign wr_ctrl  = bus.W && (bus.A == A_CTRL);
  assign wr_count = bus.W && (bus.A == A_COUNT);
  assign wr_stat  = bus.W && (bus.A == A_STAT);
  assign abort    = wr_ctrl && (bus.D[1:0] == 2'b00);

  assign Poly      = poly_q;
  assign lfsr_seed = seed_q;
  assign lfsr_load = load_q;
  assign lfsr_en   = running;
  assign busy      = running;
  assign done_irq  = irq_q;

  // Register writes, run sequencing and status flag updates
  always_comb begin
    state_d    = state_q;
    poly_d     = poly_q;
    seed_d     = seed_q;
    ctrl_d     = ctrl_q;
    count_d    = count_q;
    cnt_d      = cnt_q;
    zero_d     = zero_q;
    err_d      = err_q;
    done_d     = done_q;
    load_d     = 1'b0;
    enter_done = 1'b0;
    enter_idle = 1'b0;

    if (wr_poly) begin
      if (running) err_d = 1'b1;
      else         poly_d = bus.D;
    end
    if (wr_seed) begin
      if (running) err_d = 1'b1;
      else begin
        seed_d = bus.D;
        load_d = 1'b1;
        if (state_q == S_DONE) enter_idle = 1'b1;
      end
    end
    if (wr_count) begin
      if (running) err_d = 1'b1;
      else         count_d = CNT_W'(bus.D);
    end
    if (wr_stat) begin
      if (bus.D[3]) zero_d = 1'b0;
      if (bus.D[2]) err_d  = 1'b0;
      if (bus.D[1]) done_d = 1'b0;
    end
    if (wr_ctrl) begin
      ctrl_d = bus.D[1:0];
      if (abort) begin
        enter_idle = 1'b1;
        if (!running) done_d = 1'b0;
      end else if (running) begin
        err_d = 1'b1;
      end else begin
        done_d = 1'b0;
        case (bus.D[1:0])
          2'b01: state_d = S_STEP;
          2'b10: begin
            if (count_q != '0) begin
              state_d = S_BURST;
              cnt_d   = count_q;
            end else begin
              enter_done = 1'b1;
            end
          end
          default: state_d = S_FREE;
        endcase
      end
    end

    // An abort wins over lockup detection and step accounting in the same cycle
    if (running && !abort) begin
      if (Q == '0) begin
        zero_d     = 1'b1;
        enter_done = 1'b1;
      end else begin
        case (state_q)
          S_STEP:  enter_idle = 1'b1;
          S_BURST: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) enter_done = 1'b1;
          end
          default: ;
        endcase
      end
    end

    // Entering a resting state clears Ctrl; this overrides a same-cycle Ctrl write
    if (enter_done) begin
      state_d = S_DONE;
      done_d  = 1'b1;
      ctrl_d  = '0;
    end else if (enter_idle) begin
      state_d = S_IDLE;
      ctrl_d  = '0;
    end
  end

  // Readback selection; Status busy bit reflects the live run state
  always_comb begin
    rd_d = rd_q;
    if (bus.rd_req) begin
      case (bus.rd_addr)
        A_POLY:  rd_d = 64'(poly_q);
        A_SEED:  rd_d = 64'(Q);
        A_CTRL:  rd_d = 64'(ctrl_q);
        A_COUNT: rd_d = 64'(count_q);
        A_STAT:  rd_d = {60'd0, zero_q, err_q, done_q, running};
        default: rd_d = '0;
      endcase
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      poly_q  <= '0;
      seed_q  <= '0;
      ctrl_q  <= '0;
      count_q <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      load_q  <= 1'b0;
      irq_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      poly_q  <= poly_d;
      seed_q  <= seed_d;
      ctrl_q  <= ctrl_d;
      count_q <= count_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
      done_q  <= done_d;
      load_q  <= load_d;
      irq_q   <= enter_done;
      rd_q    <= rd_d;
    end
  end

  assign bus.rd_data = rd_q;

endmodule

// File: tb/tb_lfsr_run_ctrl.sv
// Bench for lfsr_run_ctrl: directed scenarios with literal expectations plus
// randomized MMIO traffic checked every cycle against a run-level model.
module tb_lfsr_run_ctrl;
  localparam int unsigned N  = 32;
  localparam int unsigned CW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lfsr_run_ctrl_if #(.n(N)) bus ();

  logic [N-1:0] poly, seed;
  logic [N-1:0] q = '0;
  logic         load, en, busy, irq;

  lfsr_run_ctrl #(.n(N), .CNT_W(CW)) dut (
    .clock     (clk),
    .reset     (rst),
    .bus       (bus),
    .Poly      (poly),
    .lfsr_load (load),
    .lfsr_seed (seed),
    .lfsr_en   (en),
    .Q         (q),
    .busy      (busy),
    .done_irq  (irq)
  );

  // Stand-in Galois LFSR datapath driven by the controller
  always @(posedge clk) begin
    if (load)    q <= seed;
    else if (en) q <= (q >> 1) ^ (q[0] ? poly : '0);
  end

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;
  int en_cnt = 0, busy_cnt = 0, irq_cnt = 0, load_cnt = 0, en_run = 0, en_max = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Run-level model: a run is just "cycles left" plus what happens when it ends
  logic [N-1:0]  m_poly, m_seed, m_count;
  logic [1:0]    m_ctrl;
  bit            m_zero, m_err, m_done, m_run, m_end_done, m_irq, m_load;
  longint        m_left;
  logic [63:0]   m_rd;

  task automatic model_reset();
    m_poly = '0; m_seed = '0; m_count = '0; m_ctrl = '0;
    m_zero = 0; m_err = 0; m_done = 0; m_run = 0; m_end_done = 0;
    m_irq = 0; m_load = 0; m_left = 0; m_rd = '0;
  endtask

  task automatic finish_done();
    m_run = 0; m_done = 1; m_ctrl = '0; m_irq = 1;
  endtask

  task automatic start_run(input longint left, input bit end_done);
    m_run = 1; m_left = left; m_end_done = end_done;
  endtask

  task automatic model_step();
    bit was_run, abort;
    logic [1:0] c;
    if (rst) begin
      model_reset();
      return;
    end
    was_run = m_run;
    m_irq = 0;
    m_load = 0;
    if (bus.rd_req) begin
      case (bus.rd_addr)
        16'h0010: m_rd = 64'(m_poly);
        16'h0012: m_rd = 64'(q);
        16'h0014: m_rd = 64'(m_ctrl);
        16'h0016: m_rd = 64'(m_count);
        16'h0018: m_rd = 64'({m_zero, m_err, m_done, was_run});
        default:  m_rd = '0;
      endcase
    end
    c = bus.D[1:0];
    abort = bus.W && (bus.A == 16'h0014) && (c == 2'b00);
    if (bus.W) begin
      case (bus.A)
        16'h0010: if (was_run) m_err = 1; else m_poly = bus.D;
        16'h0012: if (was_run) m_err = 1; else begin m_seed = bus.D; m_load = 1; end
        16'h0016: if (was_run) m_err = 1; else m_count = bus.D;
        16'h0018: begin
          if (bus.D[3]) m_zero = 0;
          if (bus.D[2]) m_err = 0;
          if (bus.D[1]) m_done = 0;
        end
        16'h0014: begin
          m_ctrl = c;
          if (!was_run) m_done = 0;
          if (c == 2'b00)           m_run = 0;
          else if (was_run)         m_err = 1;
          else if (c == 2'b01)      start_run(1, 0);
          else if (c == 2'b11)      start_run(-1, 0);
          else if (m_count != '0)   start_run(longint'(m_count), 1);
          else                      finish_done();
        end
        default: ;
      endcase
    end
    if (was_run && !abort) begin
      if (q == '0) begin
        m_zero = 1;
        finish_done();
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          if (m_end_done) finish_done();
          else begin m_run = 0; m_ctrl = '0; end
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Per-cycle compare against the model, plus activity counters for directed checks
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("lfsr_en",   64'(en),   64'(m_run));
        chk("busy",      64'(busy), 64'(m_run));
        chk("done_irq",  64'(irq),  64'(m_irq));
        chk("lfsr_load", 64'(load), 64'(m_load));
        chk("lfsr_seed", 64'(seed), 64'(m_seed));
        chk("Poly",      64'(poly), 64'(m_poly));
        chk("rd_data",   bus.rd_data, m_rd);
        chk("load_en_excl", 64'(load & en), 64'd0);
      end
      en_cnt   += int'(en);
      busy_cnt += int'(busy);
      irq_cnt  += int'(irq);
      load_cnt += int'(load);
      en_run    = en ? en_run + 1 : 0;
      if (en_run > en_max) en_max = en_run;
    end
  end

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    bus.W = 1'b1; bus.A = a; bus.D = d;
    @(posedge clk); #1;
    bus.W = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [63:0] v);
    bus.rd_req = 1'b1; bus.rd_addr = a;
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
    v = bus.rd_data;
  endtask

  task automatic idle(input int unsigned k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic clr_counts();
    en_cnt = 0; busy_cnt = 0; irq_cnt = 0; load_cnt = 0; en_max = 0;
  endtask

  logic [63:0] v;
  logic [15:0] amap [6] = '{16'h0010, 16'h0012, 16'h0014, 16'h0016, 16'h0018, 16'h0020};
  int unsigned guard;

  initial begin
    bus.W = 0; bus.A = '0; bus.D = '0; bus.rd_req = 0; bus.rd_addr = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    started = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: reset state
    chk("t1_en", 64'(en), 64'd0);
    chk("t1_busy", 64'(busy), 64'd0);
    rd(16'h0010, v); chk("t1_poly_rd", v, 64'd0);
    rd(16'h0014, v); chk("t1_ctrl_rd", v, 64'd0);
    rd(16'h0018, v); chk("t1_stat_rd", v, 64'd0);

    // 2: load and single step
    wr(16'h0010, 32'h8020_0003);
    clr_counts();
    wr(16'h0012, 32'h1);
    idle(2);
    chk("t2_load_pulses", 64'(load_cnt), 64'd1);
    chk("t2_seed", 64'(seed), 64'h1);
    clr_counts();
    wr(16'h0014, 32'h1);
    idle(3);
    chk("t2_en_cycles", 64'(en_cnt), 64'd1);
    rd(16'h0014, v); chk("t2_ctrl_rd", v, 64'd0);

    // 3: counted burst, then zero-length burst
    wr(16'h0016, 32'd5);
    clr_counts();
    wr(16'h0014, 32'h2);
    idle(8);
    chk("t3_en_cycles", 64'(en_cnt), 64'd5);
    chk("t3_en_consec", 64'(en_max), 64'd5);
    chk("t3_busy_cycles", 64'(busy_cnt), 64'd5);
    chk("t3_irq", 64'(irq_cnt), 64'd1);
    rd(16'h0018, v); chk("t3_stat", v, 64'h2);
    wr(16'h0016, 32'd0);
    clr_counts();
    wr(16'h0014, 32'h2);
    idle(3);
    chk("t3_zero_en", 64'(en_cnt), 64'd0);
    chk("t3_zero_irq", 64'(irq_cnt), 64'd1);
    rd(16'h0018, v); chk("t3_zero_stat", v, 64'h2);

    // 4: free run, write while busy, abort, W1C
    clr_counts();
    wr(16'h0014, 32'h3);
    idle(50);
    wr(16'h0010, 32'h0000_1234);
    idle(46);
    rd(16'h0018, v); chk("t4_stat_run", v, 64'h5);
    rd(16'h0010, v); chk("t4_poly_kept", v, 64'h8020_0003);
    wr(16'h0014, 32'h0);
    chk("t4_en_after_abort", 64'(en), 64'd0);
    idle(3);
    chk("t4_no_irq", 64'(irq_cnt), 64'd0);
    wr(16'h0018, 32'h4);
    rd(16'h0018, v); chk("t4_err_clr", v, 64'h0);

    // 5: zero lockup
    wr(16'h0012, 32'h0);
    clr_counts();
    wr(16'h0014, 32'h3);
    idle(4);
    chk("t5_en_cycles", 64'(en_cnt), 64'd1);
    chk("t5_irq", 64'(irq_cnt), 64'd1);
    rd(16'h0018, v); chk("t5_stat", v, 64'hA);

    // 6: reset mid-burst
    wr(16'h0012, 32'h1);
    wr(16'h0016, 32'd1000);
    clr_counts();
    wr(16'h0014, 32'h2);
    guard = 0;
    while (en_cnt < 500 && guard < 2000) begin @(posedge clk); #1; guard++; end
    chk("t6_reach_500", 64'(en_cnt >= 500), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_en", 64'(en), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_poly", 64'(poly), 64'd0);
    chk("t6_seed", 64'(seed), 64'd0);
    chk("t6_rd", bus.rd_data, 64'd0);
    rst = 1'b0;
    rd(16'h0016, v); chk("t6_count_rd", v, 64'd0);
    rd(16'h0018, v); chk("t6_stat_rd", v, 64'd0);
    chk("t6_irq", 64'(irq_cnt), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bus.W = ($urandom_range(0, 2) == 0);
      bus.A = amap[$urandom_range(0, 5)];
      case (bus.A)
        16'h0012: bus.D = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
        16'h0014: bus.D = 32'($urandom_range(0, 3));
        16'h0016: bus.D = 32'($urandom_range(0, 12));
        16'h0018: bus.D = 32'($urandom_range(0, 15));
        default:  bus.D = $urandom;
      endcase
      bus.rd_req  = ($urandom_range(0, 1) == 0);
      bus.rd_addr = amap[$urandom_range(0, 5)];
      rst = ($urandom_range(0, 599) == 0);
      @(posedge clk); #1;
    end
    bus.W = 0; bus.rd_req = 0; rst = 0;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
